// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline stage register with stall, flush, valid tracking, WB->ID write-through
// bypass on the read operands and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W    = 8,
  parameter int REG_W     = 3,
  parameter int NUM_RD    = 2,
  parameter int CNT_W     = 8,
  parameter int REG0_ZERO = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     ID_Valid,
  input  logic                     ID_RegWrite,
  input  logic                     ID_ALUSrc,
  input  logic [NUM_RD*DATA_W-1:0] ID_Read_Data,
  input  logic [DATA_W-1:0]        ID_Imm_Data,
  input  logic [NUM_RD*REG_W-1:0]  ID_Read_Reg_Num,
  input  logic [REG_W-1:0]         ID_Write_Reg_Num,
  input  logic                     WB_RegWrite,
  input  logic [REG_W-1:0]         WB_Write_Reg_Num,
  input  logic [DATA_W-1:0]        WB_Write_Data,
  output logic                     EX_Valid,
  output logic                     EX_RegWrite,
  output logic                     EX_ALUSrc,
  output logic [NUM_RD*DATA_W-1:0] EX_Read_Data,
  output logic [DATA_W-1:0]        EX_Imm_Data,
  output logic [NUM_RD*REG_W-1:0]  EX_Read_Reg_Num,
  output logic [REG_W-1:0]         EX_Write_Reg_Num,
  output logic [CNT_W-1:0]         Bubble_Count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                     ex_valid_r, ex_valid_s;
  logic                     ex_regwrite_r, ex_regwrite_s;
  logic                     ex_alusrc_r, ex_alusrc_s;
  logic [NUM_RD*DATA_W-1:0] ex_read_data_r, ex_read_data_s;
  logic [DATA_W-1:0]        ex_imm_data_r, ex_imm_data_s;
  logic [NUM_RD*REG_W-1:0]  ex_read_reg_num_r, ex_read_reg_num_s;
  logic [REG_W-1:0]         ex_write_reg_num_r, ex_write_reg_num_s;
  logic [CNT_W-1:0]         bubble_count_r, bubble_count_s;

  // Register 0 is never forwarded when it is hardwired to zero.
  function automatic logic hit_f(input logic wb_we, input logic [REG_W-1:0] wb_num,
                                 input logic [REG_W-1:0] num);
    logic reg0_s;
    reg0_s = (REG0_ZERO == 1) && (num == {REG_W{1'b0}});
    hit_f  = wb_we && (wb_num == num) && !reg0_s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) sat_inc_f = cnt;
    else                sat_inc_f = cnt + CNT_ONE;
  endfunction

  // Next-state selection: flush over stall over load.
  always_comb begin
    ex_valid_s         = ex_valid_r;
    ex_regwrite_s      = ex_regwrite_r;
    ex_alusrc_s        = ex_alusrc_r;
    ex_read_data_s     = ex_read_data_r;
    ex_imm_data_s      = ex_imm_data_r;
    ex_read_reg_num_s  = ex_read_reg_num_r;
    ex_write_reg_num_s = ex_write_reg_num_r;
    bubble_count_s     = bubble_count_r;
    if (Flush) begin
      ex_valid_s     = 1'b0;
      ex_regwrite_s  = 1'b0;
      ex_alusrc_s    = 1'b0;
      bubble_count_s = sat_inc_f(bubble_count_r);
    end else if (Stall) begin
      // A held instruction still picks up a register written back while it waits.
      for (int i = 0; i < NUM_RD; i++) begin
        if (ex_valid_r && hit_f(WB_RegWrite, WB_Write_Reg_Num,
                                ex_read_reg_num_r[i*REG_W +: REG_W])) begin
          ex_read_data_s[i*DATA_W +: DATA_W] = WB_Write_Data;
        end else begin
          ex_read_data_s[i*DATA_W +: DATA_W] = ex_read_data_r[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      ex_valid_s         = ID_Valid;
      ex_regwrite_s      = ID_RegWrite & ID_Valid;
      ex_alusrc_s        = ID_ALUSrc;
      ex_imm_data_s      = ID_Imm_Data;
      ex_read_reg_num_s  = ID_Read_Reg_Num;
      ex_write_reg_num_s = ID_Write_Reg_Num;
      for (int i = 0; i < NUM_RD; i++) begin
        if (hit_f(WB_RegWrite, WB_Write_Reg_Num, ID_Read_Reg_Num[i*REG_W +: REG_W])) begin
          ex_read_data_s[i*DATA_W +: DATA_W] = WB_Write_Data;
        end else begin
          ex_read_data_s[i*DATA_W +: DATA_W] = ID_Read_Data[i*DATA_W +: DATA_W];
        end
      end
      if (!ID_Valid) begin
        bubble_count_s = sat_inc_f(bubble_count_r);
      end else begin
        bubble_count_s = bubble_count_r;
      end
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_r         <= 1'b0;
      ex_regwrite_r      <= 1'b0;
      ex_alusrc_r        <= 1'b0;
      ex_read_data_r     <= {(NUM_RD*DATA_W){1'b0}};
      ex_imm_data_r      <= {DATA_W{1'b0}};
      ex_read_reg_num_r  <= {(NUM_RD*REG_W){1'b0}};
      ex_write_reg_num_r <= {REG_W{1'b0}};
      bubble_count_r     <= {CNT_W{1'b0}};
    end else begin
      ex_valid_r         <= ex_valid_s;
      ex_regwrite_r      <= ex_regwrite_s;
      ex_alusrc_r        <= ex_alusrc_s;
      ex_read_data_r     <= ex_read_data_s;
      ex_imm_data_r      <= ex_imm_data_s;
      ex_read_reg_num_r  <= ex_read_reg_num_s;
      ex_write_reg_num_r <= ex_write_reg_num_s;
      bubble_count_r     <= bubble_count_s;
    end
  end

  assign EX_Valid         = ex_valid_r;
  assign EX_RegWrite      = ex_regwrite_r;
  assign EX_ALUSrc        = ex_alusrc_r;
  assign EX_Read_Data     = ex_read_data_r;
  assign EX_Imm_Data      = ex_imm_data_r;
  assign EX_Read_Reg_Num  = ex_read_reg_num_r;
  assign EX_Write_Reg_Num = ex_write_reg_num_r;
  assign Bubble_Count     = bubble_count_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg: a default build, a CNT_W=2 build sharing its inputs,
// and a NUM_RD=1/DATA_W=16/REG_W=5 build, all checked against one behavioural model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic             v;
    logic             rw;
    logic             alu;
    logic [1:0][15:0] d;
    logic [15:0]      imm;
    logic [1:0][4:0]  rn;
    logic [4:0]       wn;
    logic             wbw;
    logic [4:0]       wbn;
    logic [15:0]      wbd;
  } in_t;

  typedef struct packed {
    logic             v;
    logic             rw;
    logic             alu;
    logic [1:0][15:0] d;
    logic [15:0]      imm;
    logic [1:0][4:0]  rn;
    logic [4:0]       wn;
    logic [31:0]      cnt;
  } st_t;

  logic Clk, Reset, Stall, Flush;
  in_t  ina, inc;
  st_t  ma, mb, mc;
  int   n_cmp, n_bad;

  logic        a_v, a_rw, a_alu;
  logic [15:0] a_data;
  logic [7:0]  a_imm;
  logic [5:0]  a_rn;
  logic [2:0]  a_wn;
  logic [7:0]  a_cnt;
  logic        b_v, b_rw, b_alu;
  logic [15:0] b_data;
  logic [7:0]  b_imm;
  logic [5:0]  b_rn;
  logic [2:0]  b_wn;
  logic [1:0]  b_cnt;
  logic        c_v, c_rw, c_alu;
  logic [15:0] c_data;
  logic [15:0] c_imm;
  logic [4:0]  c_rn;
  logic [4:0]  c_wn;
  logic [7:0]  c_cnt;

  id_ex_stage_reg dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ID_Valid(ina.v), .ID_RegWrite(ina.rw), .ID_ALUSrc(ina.alu),
    .ID_Read_Data({ina.d[1][7:0], ina.d[0][7:0]}), .ID_Imm_Data(ina.imm[7:0]),
    .ID_Read_Reg_Num({ina.rn[1][2:0], ina.rn[0][2:0]}), .ID_Write_Reg_Num(ina.wn[2:0]),
    .WB_RegWrite(ina.wbw), .WB_Write_Reg_Num(ina.wbn[2:0]), .WB_Write_Data(ina.wbd[7:0]),
    .EX_Valid(a_v), .EX_RegWrite(a_rw), .EX_ALUSrc(a_alu), .EX_Read_Data(a_data),
    .EX_Imm_Data(a_imm), .EX_Read_Reg_Num(a_rn), .EX_Write_Reg_Num(a_wn), .Bubble_Count(a_cnt)
  );

  id_ex_stage_reg #(.CNT_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ID_Valid(ina.v), .ID_RegWrite(ina.rw), .ID_ALUSrc(ina.alu),
    .ID_Read_Data({ina.d[1][7:0], ina.d[0][7:0]}), .ID_Imm_Data(ina.imm[7:0]),
    .ID_Read_Reg_Num({ina.rn[1][2:0], ina.rn[0][2:0]}), .ID_Write_Reg_Num(ina.wn[2:0]),
    .WB_RegWrite(ina.wbw), .WB_Write_Reg_Num(ina.wbn[2:0]), .WB_Write_Data(ina.wbd[7:0]),
    .EX_Valid(b_v), .EX_RegWrite(b_rw), .EX_ALUSrc(b_alu), .EX_Read_Data(b_data),
    .EX_Imm_Data(b_imm), .EX_Read_Reg_Num(b_rn), .EX_Write_Reg_Num(b_wn), .Bubble_Count(b_cnt)
  );

  id_ex_stage_reg #(.NUM_RD(1), .DATA_W(16), .REG_W(5)) dut_c (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ID_Valid(inc.v), .ID_RegWrite(inc.rw), .ID_ALUSrc(inc.alu),
    .ID_Read_Data(inc.d[0]), .ID_Imm_Data(inc.imm),
    .ID_Read_Reg_Num(inc.rn[0]), .ID_Write_Reg_Num(inc.wn),
    .WB_RegWrite(inc.wbw), .WB_Write_Reg_Num(inc.wbn), .WB_Write_Data(inc.wbd),
    .EX_Valid(c_v), .EX_RegWrite(c_rw), .EX_ALUSrc(c_alu), .EX_Read_Data(c_data),
    .EX_Imm_Data(c_imm), .EX_Read_Reg_Num(c_rn), .EX_Write_Reg_Num(c_wn), .Bubble_Count(c_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one stage entry: what EX should hold after the edge.
  function automatic st_t mdl_step(input st_t s, input in_t x, input logic rst,
                                   input logic st, input logic fl, input logic [31:0] cmax);
    st_t n;
    n = s;
    if (rst) begin
      n = '0;
    end else if (fl) begin
      n.v = 1'b0; n.rw = 1'b0; n.alu = 1'b0;
      n.cnt = (s.cnt < cmax) ? s.cnt + 32'd1 : cmax;
    end else if (st) begin
      for (int c = 0; c < 2; c++)
        if (s.v && x.wbw && x.wbn == s.rn[c] && s.rn[c] != 5'd0) n.d[c] = x.wbd;
    end else begin
      n.v = x.v; n.rw = x.v & x.rw; n.alu = x.alu;
      n.imm = x.imm; n.rn = x.rn; n.wn = x.wn;
      for (int c = 0; c < 2; c++)
        n.d[c] = (x.wbw && x.wbn == x.rn[c] && x.rn[c] != 5'd0) ? x.wbd : x.d[c];
      if (!x.v) n.cnt = (s.cnt < cmax) ? s.cnt + 32'd1 : cmax;
    end
    return n;
  endfunction

  function automatic in_t rnd_in(input int dw, input int rw);
    in_t x;
    logic [15:0] dm;
    logic [4:0]  rm;
    dm = 16'((32'd1 << dw) - 32'd1);
    rm = 5'((32'd1 << rw) - 32'd1);
    x.v   = ($urandom_range(0, 3) != 0);
    x.rw  = 1'($urandom);
    x.alu = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      x.d[c]  = 16'($urandom) & dm;
      x.rn[c] = 5'($urandom) & rm;
    end
    x.imm = 16'($urandom) & dm;
    x.wn  = 5'($urandom) & rm;
    x.wbw = 1'($urandom);
    x.wbd = 16'($urandom) & dm;
    case ($urandom_range(0, 3))
      0:       x.wbn = x.rn[0];
      1:       x.wbn = x.rn[1];
      default: x.wbn = 5'($urandom) & rm;
    endcase
    return x;
  endfunction

  task automatic check_all();
    check("a_valid", a_v, ma.v);
    check("a_regwrite", a_rw, ma.rw);
    check("a_alusrc", a_alu, ma.alu);
    check("a_data", a_data, {ma.d[1][7:0], ma.d[0][7:0]});
    check("a_imm", a_imm, ma.imm[7:0]);
    check("a_rn", a_rn, {ma.rn[1][2:0], ma.rn[0][2:0]});
    check("a_wn", a_wn, ma.wn[2:0]);
    check("a_cnt", a_cnt, ma.cnt[7:0]);
    check("b_valid", b_v, mb.v);
    check("b_data", b_data, {mb.d[1][7:0], mb.d[0][7:0]});
    check("b_cnt", b_cnt, mb.cnt[1:0]);
    check("c_valid", c_v, mc.v);
    check("c_regwrite", c_rw, mc.rw);
    check("c_alusrc", c_alu, mc.alu);
    check("c_data", c_data, mc.d[0]);
    check("c_imm", c_imm, mc.imm);
    check("c_rn", c_rn, mc.rn[0]);
    check("c_wn", c_wn, mc.wn);
    check("c_cnt", c_cnt, mc.cnt[7:0]);
  endtask

  task automatic step();
    ma = mdl_step(ma, ina, Reset, Stall, Flush, 32'd255);
    mb = mdl_step(mb, ina, Reset, Stall, Flush, 32'd3);
    mc = mdl_step(mc, inc, Reset, Stall, Flush, 32'd255);
    @(posedge Clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [1:0] exp5 [5];
    exp5 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_cmp = 0; n_bad = 0;
    ma = '0; mb = '0; mc = '0;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    ina = rnd_in(8, 3); inc = rnd_in(16, 5);
    #2;

    // Reset held with random inputs.
    for (int k = 0; k < 2; k++) begin
      Stall = 1'($urandom); Flush = 1'($urandom);
      ina = rnd_in(8, 3); inc = rnd_in(16, 5);
      step();
    end
    check("rst_valid", a_v, 1'b0);
    check("rst_data", a_data, 16'h0000);
    check("rst_cnt", a_cnt, 8'h00);

    // Plain load.
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    ina = rnd_in(8, 3); ina.v = 1'b1; ina.rw = 1'b1;
    ina.d[0] = 16'h0011; ina.d[1] = 16'h0022; ina.wbw = 1'b0;
    inc = rnd_in(16, 5); inc.v = 1'b1; inc.rw = 1'b1; inc.d[0] = 16'h1234; inc.wbw = 1'b0;
    step();
    check("s1_data", a_data, 16'h2211);
    check("s1_valid", a_v, 1'b1);
    check("s1_regwrite", a_rw, 1'b1);
    check("s1_c_data", c_data, 16'h1234);

    // WB bypass on load, then register 0 never bypassed.
    ina = rnd_in(8, 3); ina.v = 1'b1;
    ina.rn[0] = 5'd3; ina.d[0] = 16'h0011; ina.rn[1] = 5'd5; ina.d[1] = 16'h0022;
    ina.wbw = 1'b1; ina.wbn = 5'd3; ina.wbd = 16'h00A5;
    inc = rnd_in(16, 5); inc.v = 1'b1;
    inc.rn[0] = 5'd3; inc.d[0] = 16'h1111; inc.wbw = 1'b1; inc.wbn = 5'd3; inc.wbd = 16'hA5A5;
    step();
    check("s2_bypass", a_data, 16'h22A5);
    check("s2_c_bypass", c_data, 16'hA5A5);
    ina.rn[0] = 5'd0; ina.wbn = 5'd0;
    inc.rn[0] = 5'd0; inc.wbn = 5'd0;
    step();
    check("s2_reg0", a_data, 16'h2211);
    check("s2_c_reg0", c_data, 16'h1111);

    // Stall with changing ID inputs, then WB write to EX ch1's register.
    Stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ina = rnd_in(8, 3); ina.wbw = 1'b0;
      inc = rnd_in(16, 5); inc.wbw = 1'b0;
      step();
      check("s3_hold", a_data, 16'h2211);
      check("s3_hold_rn", a_rn, 6'o50);
    end
    ina = rnd_in(8, 3); ina.wbw = 1'b1; ina.wbn = 5'd5; ina.wbd = 16'h005C;
    inc = rnd_in(16, 5);
    step();
    check("s3_stall_bypass", a_data, 16'h5C11);

    // Flush beats stall; invalid load counts a bubble and gates RegWrite.
    Flush = 1'b1;
    ina = rnd_in(8, 3); inc = rnd_in(16, 5);
    step();
    check("s4_flush_valid", a_v, 1'b0);
    check("s4_flush_rw", a_rw, 1'b0);
    check("s4_flush_cnt", a_cnt, 8'd1);
    Stall = 1'b0; Flush = 1'b0;
    ina = rnd_in(8, 3); ina.v = 1'b0; ina.rw = 1'b1;
    inc = rnd_in(16, 5);
    step();
    check("s4_inv_rw", a_rw, 1'b0);
    check("s4_inv_cnt", a_cnt, 8'd2);

    // Saturation on the 2-bit counter, then reset in the middle of a stall.
    Reset = 1'b1;
    step();
    Reset = 1'b0; Flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ina = rnd_in(8, 3); inc = rnd_in(16, 5);
      step();
      check("s5_sat", b_cnt, exp5[k]);
    end
    Flush = 1'b0; Stall = 1'b1;
    ina = rnd_in(8, 3); inc = rnd_in(16, 5);
    step();
    Reset = 1'b1;
    step();
    check("s5_rst_valid", a_v, 1'b0);
    check("s5_rst_data", a_data, 16'h0000);
    check("s5_rst_bcnt", b_cnt, 2'd0);
    Reset = 1'b0; Stall = 1'b0;

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      Reset = ($urandom_range(0, 63) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      ina = rnd_in(8, 3); inc = rnd_in(16, 5);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
